// File: rtl/ce_frac_gen.sv
// Multi-channel fractional clock-enable generator: each channel pulses at NUM/DEN of clk_48.
// Optional CE_FRAC_PAUSE_EN makes the pause input freeze all channels; otherwise pause is ignored.
module ce_frac_gen #(
    parameter int NUM_CH  = 4,
    parameter int ACC_W   = 16,
    parameter int DEF_NUM = 1,
    parameter int DEF_DEN = 4
) (
    input  logic              clk_48,
    input  logic              reset,
    input  logic              resync,
    input  logic              pause,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_ch,
    input  logic [ACC_W-1:0]  cfg_num,
    input  logic [ACC_W-1:0]  cfg_den,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] ce,
    output logic              cfg_state_dbg
);

    // Config handshake: a write is taken when cfg_valid && cfg_ready on a rising edge;
    // the requester must hold cfg_valid and data until that edge. cfg_ready drops for
    // exactly the one APPLY cycle that follows an accepted write.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } cfg_state_t;

    cfg_state_t         state_q, state_d;
    logic [3:0]         sh_ch_q, sh_ch_d;
    logic [ACC_W-1:0]   sh_num_q, sh_num_d;
    logic [ACC_W-1:0]   sh_den_q, sh_den_d;
    logic               err_q, err_d;

    logic [ACC_W-1:0]   num_q [NUM_CH];
    logic [ACC_W-1:0]   num_d [NUM_CH];
    logic [ACC_W-1:0]   den_q [NUM_CH];
    logic [ACC_W-1:0]   den_d [NUM_CH];
    logic [ACC_W-1:0]   acc_q [NUM_CH];
    logic [ACC_W-1:0]   acc_d [NUM_CH];
    logic [NUM_CH-1:0]  ce_q, ce_d;

    logic [ACC_W:0]     sum;
    logic [ACC_W:0]     diff;
    logic               hold;

`ifdef CE_FRAC_PAUSE_EN
    assign hold = pause;
`else
    logic unused_pause;
    assign hold         = 1'b0;
    assign unused_pause = pause;
`endif

    assign cfg_ready     = (state_q == ST_IDLE);
    assign cfg_err       = err_q;
    assign ce            = ce_q;
    assign cfg_state_dbg = (state_q == ST_APPLY);

    always_comb begin
        state_d  = state_q;
        sh_ch_d  = sh_ch_q;
        sh_num_d = sh_num_q;
        sh_den_d = sh_den_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    sh_ch_d  = cfg_ch;
                    sh_num_d = cfg_num;
                    sh_den_d = cfg_den;
                    state_d  = ST_APPLY;
                end
            end
            ST_APPLY: begin
                state_d = ST_IDLE;
                if (int'(sh_ch_q) >= NUM_CH) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Channel update. The sum is one bit wider than the accumulator so acc+num never wraps;
    // since acc < den always holds, sum-den fits back into ACC_W bits.
    always_comb begin
        sum  = '0;
        diff = '0;
        ce_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            num_d[i] = num_q[i];
            den_d[i] = den_q[i];
            acc_d[i] = acc_q[i];
            sum  = {1'b0, acc_q[i]} + {1'b0, num_q[i]};
            diff = sum - {1'b0, den_q[i]};
            if (state_q == ST_APPLY && sh_ch_q == 4'(i)) begin
                num_d[i] = sh_num_q;
                den_d[i] = sh_den_q;
                acc_d[i] = '0;
            end else if (resync) begin
                acc_d[i] = '0;
            end else if (hold) begin
                acc_d[i] = acc_q[i];
            end else if (num_q[i] == '0 || den_q[i] == '0) begin
                acc_d[i] = '0;
            end else if (num_q[i] >= den_q[i]) begin
                ce_d[i]  = 1'b1;
                acc_d[i] = '0;
            end else if (sum >= {1'b0, den_q[i]}) begin
                ce_d[i]  = 1'b1;
                acc_d[i] = diff[ACC_W-1:0];
            end else begin
                acc_d[i] = sum[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_48 or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sh_ch_q  <= '0;
            sh_num_q <= '0;
            sh_den_q <= '0;
            err_q    <= 1'b0;
            ce_q     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                num_q[i] <= ACC_W'(DEF_NUM);
                den_q[i] <= ACC_W'(DEF_DEN);
                acc_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            sh_ch_q  <= sh_ch_d;
            sh_num_q <= sh_num_d;
            sh_den_q <= sh_den_d;
            err_q    <= err_d;
            ce_q     <= ce_d;
            for (int i = 0; i < NUM_CH; i++) begin
                num_q[i] <= num_d[i];
                den_q[i] <= den_d[i];
                acc_q[i] <= acc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_ce_frac_gen.sv
// Directed self-checking bench for ce_frac_gen; inputs driven and outputs sampled on the falling edge.
`timescale 1ns/1ps
module tb_ce_frac_gen;

    logic        clk_48;
    logic        reset;
    logic        resync;
    logic        pause;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  cfg_ch;
    logic [15:0] cfg_num;
    logic [15:0] cfg_den;
    logic        cfg_err;
    logic [3:0]  ce;
    logic        cfg_state_dbg;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_q[$];

    ce_frac_gen #(
        .NUM_CH (4),
        .ACC_W  (16),
        .DEF_NUM(1),
        .DEF_DEN(4)
    ) dut (
        .clk_48       (clk_48),
        .reset        (reset),
        .resync       (resync),
        .pause        (pause),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_num      (cfg_num),
        .cfg_den      (cfg_den),
        .cfg_err      (cfg_err),
        .ce           (ce),
        .cfg_state_dbg(cfg_state_dbg)
    );

    // clock / reset
    initial clk_48 = 1'b0;
    always #5 clk_48 = ~clk_48;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver: one config write, returns cfg_ready after the accept and apply edges
    task automatic do_write(input logic [3:0] ch, input logic [15:0] n, input logic [15:0] d,
                            output logic rdy_acc, output logic rdy_app);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_num   = n;
        cfg_den   = d;
        @(negedge clk_48);
        rdy_acc   = cfg_ready;
        cfg_valid = 1'b0;
        @(negedge clk_48);
        rdy_app   = cfg_ready;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_48);
        total++;
        if (ce !== 4'h0) begin
            bad++; $display("FAIL reset_ce: got %h want %h", ce, 4'h0);
        end
        total++;
        if (cfg_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready: got %b want 1", cfg_ready);
        end
        total++;
        if (cfg_err !== 1'b0) begin
            bad++; $display("FAIL reset_err: got %b want 0", cfg_err);
        end
    endtask

    task automatic test_defaults();
        int cnt [4];
        logic [3:0] exp;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        reset = 1'b0;
        for (int n = 1; n <= 1000; n++) begin
            @(negedge clk_48);
            if (n <= 12) begin
                exp = (n % 4 == 0) ? 4'hF : 4'h0;
                total++;
                if (ce !== exp) begin
                    bad++; $display("FAIL default_phase cycle %0d: got %h want %h", n, ce, exp);
                end
            end
            for (int i = 0; i < 4; i++) cnt[i] += int'(ce[i]);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (cnt[i] !== 250) begin
                bad++; $display("FAIL default_count ch%0d: got %0d want 250", i, cnt[i]);
            end
        end
    endtask

    task automatic test_frac_write();
        logic ra, rp;
        int cnt0, cnt1, cnt3, first, last, gap, min_gap, max_gap;
        cnt0 = 0; cnt1 = 0; cnt3 = 0; first = 0; last = 0; min_gap = 1000; max_gap = 0;
        do_write(4'd1, 16'd3, 16'd40, ra, rp);
        total++;
        if (ra !== 1'b0) begin
            bad++; $display("FAIL frac_ready_low: got %b want 0", ra);
        end
        total++;
        if (rp !== 1'b1) begin
            bad++; $display("FAIL frac_ready_back: got %b want 1", rp);
        end
        total++;
        if (ce[1] !== 1'b0) begin
            bad++; $display("FAIL frac_apply_ce: got %b want 0", ce[1]);
        end
        for (int n = 1; n <= 4000; n++) begin
            @(negedge clk_48);
            if (ce[1]) begin
                cnt1++;
                if (last > 0) begin
                    gap = n - last;
                    if (gap < min_gap) min_gap = gap;
                    if (gap > max_gap) max_gap = gap;
                end else begin
                    first = n;
                end
                last = n;
            end
            cnt0 += int'(ce[0]);
            cnt3 += int'(ce[3]);
        end
        total++;
        if (cnt1 !== 300) begin
            bad++; $display("FAIL frac_count: got %0d want 300", cnt1);
        end
        total++;
        if (first !== 14) begin
            bad++; $display("FAIL frac_first: got %0d want 14", first);
        end
        total++;
        if (max_gap !== 14 || min_gap !== 13) begin
            bad++; $display("FAIL frac_gaps: got max %0d min %0d want 14 13", max_gap, min_gap);
        end
        total++;
        if (cnt0 !== 1000 || cnt3 !== 1000) begin
            bad++; $display("FAIL frac_others: got ch0 %0d ch3 %0d want 1000 1000", cnt0, cnt3);
        end
    endtask

    task automatic test_off_and_saturate();
        logic ra, rp;
        int cnt;
        do_write(4'd2, 16'd0, 16'd4, ra, rp);
        cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_48);
            cnt += int'(ce[2]);
        end
        total++;
        if (cnt !== 0) begin
            bad++; $display("FAIL off_count: got %0d want 0", cnt);
        end
        do_write(4'd2, 16'd5, 16'd5, ra, rp);
        total++;
        if (ce[2] !== 1'b0) begin
            bad++; $display("FAIL sat_eq_apply_ce: got %b want 0", ce[2]);
        end
        cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_48);
            cnt += int'(ce[2]);
        end
        total++;
        if (cnt !== 20) begin
            bad++; $display("FAIL sat_eq_count: got %0d want 20", cnt);
        end
        do_write(4'd2, 16'd7, 16'd3, ra, rp);
        total++;
        if (ce[2] !== 1'b0) begin
            bad++; $display("FAIL sat_gt_apply_ce: got %b want 0", ce[2]);
        end
        cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_48);
            cnt += int'(ce[2]);
        end
        total++;
        if (cnt !== 20) begin
            bad++; $display("FAIL sat_gt_count: got %0d want 20", cnt);
        end
    endtask

    task automatic test_bad_channel();
        logic ra, rp;
        int cnt [4];
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        total++;
        if (cfg_err !== 1'b0) begin
            bad++; $display("FAIL err_before: got %b want 0", cfg_err);
        end
        do_write(4'd9, 16'd1, 16'd1, ra, rp);
        total++;
        if (cfg_err !== 1'b1) begin
            bad++; $display("FAIL err_set: got %b want 1", cfg_err);
        end
        for (int n = 0; n < 40; n++) begin
            @(negedge clk_48);
            for (int i = 0; i < 4; i++) cnt[i] += int'(ce[i]);
        end
        total++;
        if (cnt[0] !== 10 || cnt[1] !== 3 || cnt[2] !== 40 || cnt[3] !== 10) begin
            bad++; $display("FAIL err_ratios: got %0d %0d %0d %0d want 10 3 40 10",
                            cnt[0], cnt[1], cnt[2], cnt[3]);
        end
        total++;
        if (cfg_err !== 1'b1) begin
            bad++; $display("FAIL err_sticky: got %b want 1", cfg_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_rdy;
        exp_rdy   = 4'b1010;
        cfg_valid = 1'b1;
        cfg_ch    = 4'd3;
        cfg_num   = 16'd1;
        cfg_den   = 16'd3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_48);
            total++;
            if (cfg_ready !== exp_rdy[k]) begin
                bad++; $display("FAIL b2b_ready edge %0d: got %b want %b", k, cfg_ready, exp_rdy[k]);
            end
            if (k == 0) begin
                total++;
                if (cfg_state_dbg !== 1'b1) begin
                    bad++; $display("FAIL b2b_state: got %b want 1", cfg_state_dbg);
                end
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_resync();
        logic [3:0] got, want;
        repeat (7) @(negedge clk_48);
        resync = 1'b1;
        @(negedge clk_48);
        resync = 1'b0;
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1100);
        exp_q.push_back(4'b0101);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk_48);
            got  = ce;
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++; $display("FAIL resync_seq step %0d: got %b want %b", k, got, want);
            end
        end
        // write ch0 = 1/2 with resync landing on the apply edge
        cfg_valid = 1'b1;
        cfg_ch    = 4'd0;
        cfg_num   = 16'd1;
        cfg_den   = 16'd2;
        @(negedge clk_48);
        cfg_valid = 1'b0;
        resync    = 1'b1;
        @(negedge clk_48);
        resync    = 1'b0;
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0101);
        exp_q.push_back(4'b1100);
        exp_q.push_back(4'b0101);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk_48);
            got  = ce;
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++; $display("FAIL resync_apply step %0d: got %b want %b", k, got, want);
            end
        end
    endtask

    task automatic test_pause();
        logic ra, rp;
        int cnt_all, cnt_pause, nz_pause;
        int exp_all, exp_pause, exp_nz;
`ifdef CE_FRAC_PAUSE_EN
        exp_all = 25; exp_pause = 0; exp_nz = 0;
`else
        exp_all = 50; exp_pause = 25; exp_nz = 100;
`endif
        cnt_all = 0; cnt_pause = 0; nz_pause = 0;
        do_write(4'd0, 16'd1, 16'd4, ra, rp);
        resync = 1'b1;
        @(negedge clk_48);
        resync = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk_48);
            cnt_all += int'(ce[0]);
            if (n >= 7 && n <= 106) begin
                cnt_pause += int'(ce[0]);
                if (ce !== 4'h0) nz_pause++;
            end
            if (n == 6)   pause = 1'b1;
            if (n == 106) pause = 1'b0;
        end
        total++;
        if (cnt_pause !== exp_pause) begin
            bad++; $display("FAIL pause_window: got %0d want %0d", cnt_pause, exp_pause);
        end
        total++;
        if (nz_pause !== exp_nz) begin
            bad++; $display("FAIL pause_any_ce: got %0d want %0d", nz_pause, exp_nz);
        end
        total++;
        if (cnt_all !== exp_all) begin
            bad++; $display("FAIL pause_total: got %0d want %0d", cnt_all, exp_all);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [3:0] exp;
        cfg_valid = 1'b1;
        cfg_ch    = 4'd1;
        cfg_num   = 16'd9;
        cfg_den   = 16'd10;
        @(negedge clk_48);
        reset     = 1'b1;
        cfg_valid = 1'b0;
        @(negedge clk_48);
        total++;
        if (cfg_ready !== 1'b1 || cfg_err !== 1'b0 || ce !== 4'h0) begin
            bad++; $display("FAIL midreset_state: got rdy %b err %b ce %h want 1 0 0",
                            cfg_ready, cfg_err, ce);
        end
        @(negedge clk_48);
        reset = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk_48);
            exp = (n % 4 == 0) ? 4'hF : 4'h0;
            total++;
            if (ce !== exp) begin
                bad++; $display("FAIL midreset_defaults cycle %0d: got %h want %h", n, ce, exp);
            end
        end
        total++;
        if (cfg_ready !== 1'b1) begin
            bad++; $display("FAIL midreset_ready: got %b want 1", cfg_ready);
        end
    endtask

    initial begin
        reset     = 1'b1;
        resync    = 1'b0;
        pause     = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = 4'd0;
        cfg_num   = 16'd0;
        cfg_den   = 16'd0;
        test_reset();
        test_defaults();
        test_frac_write();
        test_off_and_saturate();
        test_bad_channel();
        test_back_to_back();
        test_resync();
        test_pause();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
